// File: rtl/pll_lock_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the downstream reset; re-pulses on timeout, lock loss or software request.
module pll_lock_reset_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       sw_relock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    localparam int MAX_AB  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             w_timeout_set;
    logic             w_lock_lost;

    // NOTE: lock is asynchronous to clkin; only the second flop's output may fan out.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_timeout_set = 1'b0;
        w_lock_lost   = 1'b0;
        if (sw_relock) begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nxt   = ST_PLL_RST;
                        w_cnt_nxt     = '0;
                        w_timeout_set = 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A lock glitch restarts the stability window without re-resetting the PLL.
                    if (!r_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!r_lock_s) begin
                        w_state_nxt = ST_PLL_RST;
                        w_lock_lost = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            pll_reset   <= 1'b1;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            relock_cnt  <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            pll_reset   <= (w_state_nxt == ST_PLL_RST);
            sys_rst_n   <= (w_state_nxt == ST_RUN);
            ready       <= (w_state_nxt == ST_RUN);
            timeout_err <= timeout_err | w_timeout_set;
            if (w_lock_lost && relock_cnt != 8'hFF) begin
                relock_cnt <= relock_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq: a countdown-based phase model predicts the
// outputs after every clkin edge; a separate monitor pops and compares each cycle.
module tb_pll_lock_reset_seq;

    localparam int R = 4;
    localparam int S = 8;
    localparam int T = 32;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    typedef struct packed {
        logic       pll_reset;
        logic       sys_rst_n;
        logic       ready;
        logic [7:0] relock_cnt;
        logic       timeout_err;
    } out_t;

    localparam out_t RESET_OUT = {1'b1, 1'b0, 1'b0, 8'd0, 1'b0};

    logic       clkin = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock = 1'b0;
    logic       sw_relock = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] relock_cnt;
    logic       timeout_err;

    pll_lock_reset_seq #(
        .RST_CYCLES    (R),
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .lock       (lock),
        .sw_relock  (sw_relock),
        .pll_reset  (pll_reset),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .relock_cnt (relock_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clkin = ~clkin;

    out_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: current phase plus cycles left before it expires.
    int   m_phase;
    int   m_left;
    int   m_relocks;
    bit   m_timeout;
    bit   m_hist[$];

    function automatic out_t cur_out();
        return {pll_reset, sys_rst_n, ready, relock_cnt, timeout_err};
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got {pll_reset=%0b sys_rst_n=%0b ready=%0b relock_cnt=%0d timeout_err=%0b} want {pll_reset=%0b sys_rst_n=%0b ready=%0b relock_cnt=%0d timeout_err=%0b}",
                     name, cyc, act.pll_reset, act.sys_rst_n, act.ready, act.relock_cnt, act.timeout_err,
                     exp.pll_reset, exp.sys_rst_n, exp.ready, exp.relock_cnt, exp.timeout_err);
        end
    endtask

    function automatic void model_reset();
        m_phase   = PH_PULSE;
        m_left    = R;
        m_relocks = 0;
        m_timeout = 1'b0;
        m_hist    = {1'b0, 1'b0};
    endfunction

    function automatic void model_pulse();
        m_phase = PH_PULSE;
        m_left  = R;
    endfunction

    // Lock seen by the sequencer at an edge is the pin value from two edges earlier.
    function automatic void model_step(input bit lk, input bit sw);
        bit ls;
        m_hist.push_back(lk);
        ls = m_hist.pop_front();
        if (sw) begin
            model_pulse();
            return;
        end
        case (m_phase)
            PH_PULSE: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = PH_WAIT;
                    m_left  = T;
                end
            end
            PH_WAIT: begin
                if (ls) begin
                    m_phase = PH_STABLE;
                    m_left  = S;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_timeout = 1'b1;
                        model_pulse();
                    end
                end
            end
            PH_STABLE: begin
                if (!ls) begin
                    m_phase = PH_WAIT;
                    m_left  = T;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_RUN;
                end
            end
            default: begin
                if (!ls) begin
                    if (m_relocks < 255) m_relocks++;
                    model_pulse();
                end
            end
        endcase
    endfunction

    function automatic out_t model_out();
        return {(m_phase == PH_PULSE), (m_phase == PH_RUN), (m_phase == PH_RUN),
                8'(m_relocks), m_timeout};
    endfunction

    // Called at a negedge: drive inputs for the next edge, predict, wait for next negedge.
    task automatic cycle(input bit lk, input bit sw);
        lock      = lk;
        sw_relock = sw;
        model_step(lk, sw);
        sb_q.push_back(model_out());
        @(negedge clkin);
    endtask

    task automatic hold(input bit lk, input int n);
        repeat (n) cycle(lk, 1'b0);
    endtask

    task automatic drive_until(input int ph, input bit lk, input int max_cyc);
        int n = 0;
        while (m_phase != ph && n < max_cyc) begin
            cycle(lk, 1'b0);
            n++;
        end
    endtask

    task automatic do_reset(input int hold_cyc);
        #2 reset_n = 1'b0;
        #1 check("async_reset", cur_out(), RESET_OUT);
        sb_q.delete();
        model_reset();
        lock      = 1'b0;
        sw_relock = 1'b0;
        repeat (hold_cyc) begin
            @(negedge clkin);
            check("reset_hold", cur_out(), RESET_OUT);
        end
        reset_n = 1'b1;
    endtask

    // Monitor: registered outputs are presented every edge while out of reset.
    initial begin
        forever begin
            @(posedge clkin);
            #1;
            cyc++;
            if (reset_n) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty cycle=%0d got no expectation want one queued", cyc);
                end else begin
                    check("outputs", cur_out(), sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog got time limit want stimulus complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clkin);
        check("por_reset", cur_out(), RESET_OUT);
        reset_n = 1'b1;

        // Bring-up with late lock, then a glitch while stable.
        hold(1'b0, 10);
        hold(1'b1, 30);
        hold(1'b0, 2);
        drive_until(PH_STABLE, 1'b1, 40);
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 20);

        // Lock never arrives: repeated timeouts.
        hold(1'b0, 100);
        hold(1'b1, 30);

        // Software relock in RUN, and coincident with a lock loss.
        cycle(1'b1, 1'b1);
        hold(1'b1, 30);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        hold(1'b1, 30);

        // Mid-STABLE and mid-pulse resets.
        hold(1'b0, 3);
        drive_until(PH_STABLE, 1'b1, 60);
        hold(1'b1, 2);
        do_reset(2);
        hold(1'b1, 2);
        do_reset(1);
        hold(1'b1, 30);

        // Saturate the relock counter.
        repeat (300) begin
            hold(1'b0, 2);
            hold(1'b1, 20);
        end

        // Randomized lock segments with sparse software requests and resets.
        repeat (80) begin
            bit lk;
            int n;
            lk = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 45);
            for (int i = 0; i < n; i++) begin
                cycle(lk, ($urandom_range(0, 49) == 0));
            end
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end

        hold(1'b1, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
